// File: rtl/pipe_ctrl.sv
// Hazard and flush controller for the 5-stage core: load-use stalls, jump flushes,
// bus wait-state freezes with capture/replay of a jump, plus stall/flush event counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow; jumps issue immediately, load-use inserts a bubble
// BUSW  | bus wait in progress; front end frozen, first jump held pending
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             ex_mem_rd_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_ren_i,
  input  logic             id_rs2_ren_i,
  input  logic             bus_busy_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    RUN  = 1'b0,
    BUSW = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic        lu;

  assign lu = ex_mem_rd_i && (ex_rd_addr_i != 5'd0) &&
              ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
               (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Outputs are forced low while reset is asserted, independent of the inputs.
  always_comb begin
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    if (rst) begin
      if (bus_busy_i) begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
      end else if ((state == BUSW) && pend_vld) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = pend_addr;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (jump_en_i) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (lu) begin
        hold_pc_o     = 1'b1;
        hold_if_id_o  = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_vld  <= 1'b0;
      pend_addr <= 32'd0;
    end else if (bus_busy_i) begin
      state <= BUSW;
      // Only the oldest jump seen during the wait is kept.
      if (jump_en_i && !pend_vld) begin
        pend_vld  <= 1'b1;
        pend_addr <= jump_addr_i;
      end
    end else begin
      state     <= RUN;
      pend_vld  <= 1'b0;
      pend_addr <= 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_pc_o) stall_cnt_o <= stall_cnt_o + CNT_ONE;
      if (jump_en_o) flush_cnt_o <= flush_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized
// traffic, compared cycle by cycle against a queue-based behavioural model.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_mem_rd_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_ren_i;
  logic        id_rs2_ren_i;
  logic        bus_busy_i;

  logic        hold_pc_o, hold_if_id_o, hold_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o, jump_en_o;
  logic [31:0] jump_addr_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  logic        hold_pc_n, hold_if_id_n, hold_id_ex_n;
  logic        flush_if_id_n, flush_id_ex_n, jump_en_n;
  logic [31:0] jump_addr_n;
  logic [3:0]  stall_cnt_n, flush_cnt_n;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .bus_busy_i(bus_busy_i),
    .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_ctrl #(.CNT_W(4)) dut_n (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .bus_busy_i(bus_busy_i),
    .hold_pc_o(hold_pc_n), .hold_if_id_o(hold_if_id_n), .hold_id_ex_o(hold_id_ex_n),
    .flush_if_id_o(flush_if_id_n), .flush_id_ex_o(flush_id_ex_n),
    .jump_en_o(jump_en_n), .jump_addr_o(jump_addr_n),
    .stall_cnt_o(stall_cnt_n), .flush_cnt_o(flush_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: "in_wait" means the previous clocked cycle had the bus busy.
  logic        in_wait;
  logic [31:0] pend_q[$];
  logic [31:0] m_stall, m_flush;
  logic [36:0] e_ctrl;
  logic [36:0] s_ctrl, s_ctrl_n;

  function automatic logic [36:0] pack(input logic hp, hi, he, fi, fe, je, input logic [31:0] ja);
    return {hp, hi, he, fi, fe, je, ja};
  endfunction

  function automatic logic load_use();
    logic rs1_hit, rs2_hit;
    rs1_hit = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i);
    return ex_mem_rd_i && (ex_rd_addr_i != 0) && (rs1_hit || rs2_hit);
  endfunction

  task automatic model_comb();
    if (!rst)                                e_ctrl = '0;
    else if (bus_busy_i)                     e_ctrl = pack(1, 1, 1, 0, 0, 0, 0);
    else if (in_wait && pend_q.size() > 0)   e_ctrl = pack(0, 0, 0, 1, 1, 1, pend_q[0]);
    else if (jump_en_i)                      e_ctrl = pack(0, 0, 0, 1, 1, 1, jump_addr_i);
    else if (load_use())                     e_ctrl = pack(1, 1, 0, 0, 1, 0, 0);
    else                                     e_ctrl = '0;
  endtask

  task automatic model_reset();
    in_wait = 0;
    pend_q.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_clock();
    if (!rst) begin
      model_reset();
    end else begin
      m_stall += {31'd0, e_ctrl[36]};
      m_flush += {31'd0, e_ctrl[32]};
      if (bus_busy_i) begin
        if (jump_en_i && pend_q.size() == 0) pend_q.push_back(jump_addr_i);
        in_wait = 1;
      end else begin
        pend_q.delete();
        in_wait = 0;
      end
    end
  endtask

  task automatic check_counters();
    chk("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, m_stall});
    chk("flush_cnt", {32'd0, flush_cnt_o}, {32'd0, m_flush});
    chk("stall_cnt4", {60'd0, stall_cnt_n}, {60'd0, m_stall[3:0]});
    chk("flush_cnt4", {60'd0, flush_cnt_n}, {60'd0, m_flush[3:0]});
  endtask

  // Called at posedge+1: sample outputs at the falling edge, then clock the model.
  task automatic step();
    #4;
    model_comb();
    s_ctrl   = pack(hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o, jump_en_o, jump_addr_o);
    s_ctrl_n = pack(hold_pc_n, hold_if_id_n, hold_id_ex_n, flush_if_id_n, flush_id_ex_n, jump_en_n, jump_addr_n);
    chk("ctrl", {27'd0, s_ctrl}, {27'd0, e_ctrl});
    chk("ctrl4", {27'd0, s_ctrl_n}, {27'd0, e_ctrl});
    @(posedge clk);
    #1;
    model_clock();
    check_counters();
  endtask

  task automatic drive(input logic je, input logic [31:0] ja, input logic mrd, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic r1, input logic r2,
                       input logic busy);
    jump_en_i     = je;
    jump_addr_i   = ja;
    ex_mem_rd_i   = mrd;
    ex_rd_addr_i  = rd;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    id_rs1_ren_i  = r1;
    id_rs2_ren_i  = r2;
    bus_busy_i    = busy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] base_s, base_f;

  initial begin
    model_reset();
    rst = 1'b0;
    // Hazard inputs active during reset must not reach the outputs.
    drive(1, 32'hdead_beef, 1, 5, 5, 0, 1, 0, 1);
    #3;
    chk("rst_ctrl", {27'd0, pack(hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
                                 jump_en_o, jump_addr_o)}, 64'd0);
    chk("rst_stall", {32'd0, stall_cnt_o}, 64'd0);
    chk("rst_flush", {32'd0, flush_cnt_o}, 64'd0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    step();

    // Load-use on rs1, then the same pattern with rd=0, then rs2 match.
    base_s = m_stall;
    drive(0, 0, 1, 5, 5, 0, 1, 0, 0);
    step();
    chk("lu_ctrl", {27'd0, s_ctrl}, {27'd0, pack(1, 1, 0, 0, 1, 0, 0)});
    chk("lu_stall", {32'd0, stall_cnt_o}, {32'd0, base_s + 32'd1});
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0);
    step();
    chk("lu_rd0", {27'd0, s_ctrl}, 64'd0);
    drive(0, 0, 1, 9, 3, 9, 1, 1, 0);
    step();
    drive(0, 0, 1, 9, 3, 9, 1, 0, 0);
    step();
    idle();
    step();

    // Jump in the same cycle as a load-use hazard.
    base_f = m_flush;
    drive(1, 32'h0000_0100, 1, 5, 5, 0, 1, 0, 0);
    step();
    chk("jmp_lu", {27'd0, s_ctrl}, {27'd0, pack(0, 0, 0, 1, 1, 1, 32'h100)});
    chk("jmp_cnt", {32'd0, flush_cnt_o}, {32'd0, base_f + 32'd1});

    // Jump captured during a 3-cycle bus wait; a second jump is ignored.
    base_s = m_stall;
    base_f = m_flush;
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("cap_hold", {27'd0, s_ctrl}, {27'd0, pack(1, 1, 1, 0, 0, 0, 0)});
    drive(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("cap_rel", {27'd0, s_ctrl}, {27'd0, pack(0, 0, 0, 1, 1, 1, 32'h200)});
    idle();
    step();
    chk("cap_idle", {27'd0, s_ctrl}, 64'd0);
    chk("cap_stall", {32'd0, stall_cnt_o}, {32'd0, base_s + 32'd3});
    chk("cap_flush", {32'd0, flush_cnt_o}, {32'd0, base_f + 32'd1});

    // Plain bus wait followed by a load-use cycle.
    base_s = m_stall;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    drive(0, 0, 1, 7, 0, 7, 0, 1, 0);
    step();
    chk("bw_lu", {27'd0, s_ctrl}, {27'd0, pack(1, 1, 0, 0, 1, 0, 0)});
    chk("bw_stall", {32'd0, stall_cnt_o}, {32'd0, base_s + 32'd3});

    // Reset asserted mid-cycle while a jump is pending in the bus wait.
    drive(1, 32'h500, 0, 0, 0, 0, 0, 0, 1);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_ctrl", {27'd0, pack(hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
                                  jump_en_o, jump_addr_o)}, 64'd0);
    chk("mrst_stall", {32'd0, stall_cnt_o}, 64'd0);
    chk("mrst_flush", {32'd0, flush_cnt_o}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    step();
    chk("mrst_nojmp", {27'd0, s_ctrl}, 64'd0);

    // 17 load-use stalls wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 4, 4, 0, 1, 0, 0);
      step();
    end
    chk("wrap4", {60'd0, stall_cnt_n}, 64'd1);
    chk("wrap32", {32'd0, stall_cnt_o}, 64'd17);

    // Randomized traffic with small register indices to hit hazards often.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom(), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
